// File: rtl/uart_fmap_pkg.sv
// ---------------------------------------------------------------------------
// uart_fmap_pkg
// Shared definitions for the feature-map UART receiver:
//   - PIX_W          : width of one map element (one UART byte)
//   - DEF_ROWS/COLS  : default map geometry
//   - rx_state_t     : bit-level receiver FSM states
//   - clks_per_bit() : system clocks per serial bit (integer division)
// ---------------------------------------------------------------------------
package uart_fmap_pkg;

    localparam int PIX_W    = 8;
    localparam int DEF_ROWS = 6;
    localparam int DEF_COLS = 6;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
// 8N1 byte receiver: 2-flop synchronizer on the serial line followed by a
// start/data/stop bit FSM. Data bits are shifted in LSB first.
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   rxd         in   raw serial line (idle high, asynchronous)
//   byte_data   out  last assembled byte (valid while byte_valid=1)
//   byte_valid  out  one-cycle pulse: stop bit sampled high
//   frame_error out  one-cycle pulse: stop bit sampled low, byte dropped
//   line_idle   out  bit FSM is in IDLE
//   start_seen  out  IDLE with synchronized line low (start edge detected)
// ---------------------------------------------------------------------------
module uart_rx_byte
    import uart_fmap_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rxd,
    output logic [PIX_W-1:0] byte_data,
    output logic             byte_valid,
    output logic             frame_error,
    output logic             line_idle,
    output logic             start_seen
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta_reg;
    logic             rx_sync_reg;
    rx_state_t        state_reg;
    rx_state_t        state_next;
    logic [CNT_W-1:0] clk_cnt_reg;
    logic [CNT_W-1:0] clk_cnt_next;
    logic [2:0]       bit_cnt_reg;
    logic [PIX_W-1:0] shift_reg;
    logic             byte_valid_reg;
    logic             frame_error_reg;
    logic             start_tick;
    logic             bit_tick;
    logic             stop_tick;

    // Synchronizer resets to the idle (high) line level so reset release
    // never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rxd;
            rx_sync_reg <= rx_meta_reg;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= RX_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RX_IDLE: begin
                if (!rx_sync_reg) begin
                    state_next = RX_START;
                end
            end
            RX_START: begin
                // A line that is high again at mid-start-bit was a glitch.
                if (start_tick) begin
                    state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (bit_tick && (bit_cnt_reg == 3'd7)) begin
                    state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (stop_tick) begin
                    state_next = RX_IDLE;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    // Output / strobe decode
    always_comb begin
        start_tick = (state_reg == RX_START) && (clk_cnt_reg == HALF_CNT);
        bit_tick   = (state_reg == RX_DATA)  && (clk_cnt_reg == LAST_CNT);
        stop_tick  = (state_reg == RX_STOP)  && (clk_cnt_reg == LAST_CNT);
        line_idle  = (state_reg == RX_IDLE);
        start_seen = (state_reg == RX_IDLE) && !rx_sync_reg;
        // The bit timer restarts on every state change and on every data
        // sample, so each sample lands one full bit after the previous one.
        if ((state_next != state_reg) || bit_tick || (state_reg == RX_IDLE)) begin
            clk_cnt_next = '0;
        end else begin
            clk_cnt_next = clk_cnt_reg + 1'b1;
        end
    end

    // Datapath: bit timer, bit counter, shift register, result pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_cnt_reg     <= '0;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            byte_valid_reg  <= 1'b0;
            frame_error_reg <= 1'b0;
        end else begin
            clk_cnt_reg     <= clk_cnt_next;
            byte_valid_reg  <= stop_tick && rx_sync_reg;
            frame_error_reg <= stop_tick && !rx_sync_reg;
            if (state_reg == RX_IDLE) begin
                bit_cnt_reg <= '0;
            end else if (bit_tick) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                shift_reg   <= {rx_sync_reg, shift_reg[PIX_W-1:1]};
            end
        end
    end

    assign byte_data   = shift_reg;
    assign byte_valid  = byte_valid_reg;
    assign frame_error = frame_error_reg;

endmodule

// File: rtl/uart_rx_f_map.sv
// ---------------------------------------------------------------------------
// uart_rx_f_map
// Receives a ROWS x COLS map of bytes (row-major, col inner) over an 8N1
// serial line, buffers it in a shadow map and publishes the complete map
// atomically together with a one-cycle map_valid pulse.
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   RxD         in   serial line, idle high, asynchronous to clk
//   receive     in   1 = accept bytes; 0 = drop bytes, pointer held at (0,0)
//   data        out  last complete map, stable between completions
//   map_valid   out  one-cycle pulse: data just updated
//   busy        out  partial map pending (pointer != (0,0))
//   frame_error out  one-cycle pulse: byte dropped on bad stop bit
//   timeout     out  one-cycle pulse: partial map discarded after idle time
// ---------------------------------------------------------------------------
module uart_rx_f_map
    import uart_fmap_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 9600,
    parameter int ROWS         = DEF_ROWS,
    parameter int COLS         = DEF_COLS,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     RxD,
    input  logic                                     receive,
    output logic [0:ROWS-1][0:COLS-1][PIX_W-1:0]     data,
    output logic                                     map_valid,
    output logic                                     busy,
    output logic                                     frame_error,
    output logic                                     timeout
);

    localparam int               CPB       = clks_per_bit(CLK_FREQ, BAUD);
    localparam int               TO_CYCLES = TIMEOUT_BITS * CPB;
    localparam int               TO_W      = $clog2(TO_CYCLES + 1);
    localparam int               ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int               COL_W     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYCLES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);

    logic [PIX_W-1:0]                      rx_byte;
    logic                                  byte_valid;
    logic                                  line_idle;
    logic                                  start_seen;

    logic [ROW_W-1:0]                      row_reg;
    logic [ROW_W-1:0]                      row_next;
    logic [COL_W-1:0]                      col_reg;
    logic [COL_W-1:0]                      col_next;
    logic                                  busy_reg;
    logic                                  map_valid_reg;
    logic                                  timeout_reg;
    logic [TO_W-1:0]                       to_cnt_reg;
    logic                                  to_expired;
    logic                                  wr_en;
    logic                                  map_done;
    logic                                  timeout_fire;
    logic [0:ROWS-1][0:COLS-1][PIX_W-1:0]  shadow_reg;
    logic [0:ROWS-1][0:COLS-1][PIX_W-1:0]  data_reg;

    uart_rx_byte #(
        .CLKS_PER_BIT (CPB)
    ) u_rx_byte (
        .clk         (clk),
        .reset       (reset),
        .rxd         (RxD),
        .byte_data   (rx_byte),
        .byte_valid  (byte_valid),
        .frame_error (frame_error),
        .line_idle   (line_idle),
        .start_seen  (start_seen)
    );

    // A start edge in the same cycle as expiry wins: the map keeps going.
    assign to_expired = busy_reg && line_idle && !start_seen && (to_cnt_reg == TO_LAST);

    // Write pointer / completion decode. receive=0 dominates, then a good
    // byte, then inactivity expiry.
    always_comb begin
        row_next     = row_reg;
        col_next     = col_reg;
        wr_en        = 1'b0;
        map_done     = 1'b0;
        timeout_fire = 1'b0;
        if (!receive) begin
            row_next = '0;
            col_next = '0;
        end else if (byte_valid) begin
            wr_en = 1'b1;
            if (col_reg == COL_LAST) begin
                col_next = '0;
                if (row_reg == ROW_LAST) begin
                    row_next = '0;
                    map_done = 1'b1;
                end else begin
                    row_next = row_reg + 1'b1;
                end
            end else begin
                col_next = col_reg + 1'b1;
            end
        end else if (to_expired) begin
            row_next     = '0;
            col_next     = '0;
            timeout_fire = 1'b1;
        end
    end

    // busy is derived from the next pointer so it always matches row/col.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_reg       <= '0;
            col_reg       <= '0;
            busy_reg      <= 1'b0;
            map_valid_reg <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            row_reg       <= row_next;
            col_reg       <= col_next;
            busy_reg      <= (row_next != '0) || (col_next != '0);
            map_valid_reg <= map_done;
            timeout_reg   <= timeout_fire;
        end
    end

    // Inactivity timer: runs only between bytes of a pending map.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_reg <= '0;
        end else if (!busy_reg || start_seen || timeout_fire) begin
            to_cnt_reg <= '0;
        end else if (line_idle) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
        end
    end

    // Shadow and output map elements. The last element of the output map
    // takes the incoming byte directly, since its shadow copy is written on
    // the same edge.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            localparam logic [ROW_W-1:0] R_IDX   = ROW_W'(gi);
            localparam logic [COL_W-1:0] C_IDX   = COL_W'(gj);
            localparam bit               IS_LAST = (gi == ROWS - 1) && (gj == COLS - 1);

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    shadow_reg[gi][gj] <= '0;
                    data_reg[gi][gj]   <= '0;
                end else begin
                    if (wr_en && (row_reg == R_IDX) && (col_reg == C_IDX)) begin
                        shadow_reg[gi][gj] <= rx_byte;
                    end
                    if (map_done) begin
                        data_reg[gi][gj] <= IS_LAST ? rx_byte : shadow_reg[gi][gj];
                    end
                end
            end
        end
    end

    assign data      = data_reg;
    assign map_valid = map_valid_reg;
    assign busy      = busy_reg;
    assign timeout   = timeout_reg;

endmodule
